// File: rtl/gpu_cmd_pkg.sv
// Shared sprite command word definitions: field widths and positions, idle word,
// opcode set, FIFO entry layout and the encoder sequencer states.
package gpu_cmd_pkg;

    localparam int CMD_OP_W   = 4;
    localparam int CMD_IDX_W  = 8;
    localparam int CMD_DATA_W = 23;
    localparam int CMD_WORD_W = 35;

    localparam int CMD_OP_MSB   = 34;
    localparam int CMD_OP_LSB   = 31;
    localparam int CMD_IDX_MSB  = 30;
    localparam int CMD_IDX_LSB  = 23;
    localparam int CMD_DATA_MSB = 22;
    localparam int CMD_DATA_LSB = 0;

    localparam logic [CMD_WORD_W-1:0] CMD_IDLE = '0;

    typedef enum logic [CMD_OP_W-1:0] {
        OP_NOP      = 4'd0,
        OP_SET_POS  = 4'd1,
        OP_SET_TILE = 4'd2,
        OP_SET_ATTR = 4'd3,
        OP_SET_PAL  = 4'd4,
        OP_ENABLE   = 4'd5,
        OP_DISABLE  = 4'd6,
        OP_SET_PRIO = 4'd7
    } sprite_op_e;

    typedef struct packed {
        logic [CMD_OP_W-1:0]   op;
        logic [CMD_IDX_W-1:0]  idx;
        logic [CMD_IDX_W-1:0]  last;
        logic                  bcast;
        logic [CMD_DATA_W-1:0] payload;
    } fifo_entry_t;

    localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } enc_state_t;

    function automatic logic [CMD_WORD_W-1:0] cmd_pack(
        input logic [CMD_OP_W-1:0]   op,
        input logic [CMD_IDX_W-1:0]  idx,
        input logic [CMD_DATA_W-1:0] data
    );
        logic [CMD_WORD_W-1:0] word;
        word = CMD_IDLE;
        word[CMD_OP_MSB:CMD_OP_LSB]     = op;
        word[CMD_IDX_MSB:CMD_IDX_LSB]   = idx;
        word[CMD_DATA_MSB:CMD_DATA_LSB] = data;
        return word;
    endfunction

endpackage

// File: rtl/sprite_command_encoder_cmd_fifo.sv
// cmd_fifo: synchronous FIFO with push/pop/full/empty/count. The head is read
// combinationally so the sequencer can pop and issue on the same edge.
module cmd_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage is not reset; occupancy is tracked solely by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_command_encoder.sv
// Sprite command encoder: buffers CPU requests and issues 35-bit command words,
// expanding broadcasts over an index range. Optional macro ENCODER_ISSUE_COUNT_EN adds IssueCount.
module sprite_command_encoder
    import gpu_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [CMD_OP_W-1:0]   CmdOpcode,
    input  logic [CMD_IDX_W-1:0]  CmdIndex,
    input  logic [CMD_IDX_W-1:0]  CmdLast,
    input  logic                  CmdBcast,
    input  logic [CMD_DATA_W-1:0] CmdPayload,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  Stall,
    output logic [CMD_WORD_W-1:0] DataOut,
`ifdef ENCODER_ISSUE_COUNT_EN
    output logic [15:0]           IssueCount,
`endif
    output logic                  Busy
);

    enc_state_t            r_state;
    enc_state_t            w_state_next;
    logic [CMD_OP_W-1:0]   r_cur_op;
    logic [CMD_OP_W-1:0]   w_cur_op_next;
    logic [CMD_IDX_W-1:0]  r_cur_idx;
    logic [CMD_IDX_W-1:0]  w_cur_idx_next;
    logic [CMD_IDX_W-1:0]  r_end_idx;
    logic [CMD_IDX_W-1:0]  w_end_idx_next;
    logic [CMD_DATA_W-1:0] r_payload;
    logic [CMD_DATA_W-1:0] w_payload_next;
    logic [CMD_WORD_W-1:0] r_data_out;
    logic [CMD_WORD_W-1:0] w_data_next;

    fifo_entry_t           w_fifo_in;
    fifo_entry_t           w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [PTR_W:0]        w_fifo_count;

    // No-op requests are handshaken away here and never reach the FIFO.
    assign w_push    = CmdValid & ~w_fifo_full & (CmdOpcode != '0);
    assign w_fifo_in = '{op: CmdOpcode, idx: CmdIndex, last: CmdLast,
                         bcast: CmdBcast, payload: CmdPayload};

    cmd_fifo #(
        .WIDTH (FIFO_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_cmd_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_next   = r_state;
        w_cur_op_next  = r_cur_op;
        w_cur_idx_next = r_cur_idx;
        w_end_idx_next = r_end_idx;
        w_payload_next = r_payload;
        w_data_next    = CMD_IDLE;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !Stall) begin
                    w_pop          = 1'b1;
                    w_cur_op_next  = w_head.op;
                    w_end_idx_next = w_head.last;
                    w_payload_next = w_head.payload;
                    w_cur_idx_next = w_head.idx;
                    w_data_next    = cmd_pack(w_head.op, w_head.idx, w_head.payload);
                    if (w_head.bcast && (w_head.last > w_head.idx)) begin
                        w_state_next   = ST_BCAST;
                        w_cur_idx_next = w_head.idx + 8'd1;
                    end
                end
            end
            ST_BCAST: begin
                if (!Stall) begin
                    w_data_next = cmd_pack(r_cur_op, r_cur_idx, r_payload);
                    // Stop on the end index itself so a range ending at 255 never wraps.
                    if (r_cur_idx == r_end_idx) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cur_idx_next = r_cur_idx + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_cur_op   <= '0;
            r_cur_idx  <= '0;
            r_end_idx  <= '0;
            r_payload  <= '0;
            r_data_out <= CMD_IDLE;
        end else begin
            r_state    <= w_state_next;
            r_cur_op   <= w_cur_op_next;
            r_cur_idx  <= w_cur_idx_next;
            r_end_idx  <= w_end_idx_next;
            r_payload  <= w_payload_next;
            r_data_out <= w_data_next;
        end
    end

`ifdef ENCODER_ISSUE_COUNT_EN
    logic [15:0] r_issue_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_issue_count <= '0;
        end else if (w_data_next != CMD_IDLE) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    assign IssueCount = r_issue_count;
`endif

    assign CmdReady = ~w_fifo_full;
    assign DataOut  = r_data_out;
    assign Busy     = (w_fifo_count != '0) | (r_state != ST_IDLE);

endmodule

// File: tb/tb_sprite_command_encoder.sv
// Directed bench for sprite_command_encoder: single, broadcast, boundary,
// back-pressure, mid-broadcast stall and mid-broadcast reset scenarios.
module tb_sprite_command_encoder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  CmdOpcode = '0;
    logic [7:0]  CmdIndex = '0;
    logic [7:0]  CmdLast = '0;
    logic        CmdBcast = 1'b0;
    logic [22:0] CmdPayload = '0;
    logic        CmdValid = 1'b0;
    logic        CmdReady;
    logic        Stall = 1'b0;
    logic [34:0] DataOut;
    logic        Busy;
`ifdef ENCODER_ISSUE_COUNT_EN
    logic [15:0] IssueCount;
`endif

    int n_total = 0;
    int n_bad   = 0;

    sprite_command_encoder dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CmdOpcode  (CmdOpcode),
        .CmdIndex   (CmdIndex),
        .CmdLast    (CmdLast),
        .CmdBcast   (CmdBcast),
        .CmdPayload (CmdPayload),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .Stall      (Stall),
        .DataOut    (DataOut),
`ifdef ENCODER_ISSUE_COUNT_EN
        .IssueCount (IssueCount),
`endif
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [34:0] word(input logic [3:0] op, input logic [7:0] idx,
                                         input logic [22:0] pl);
        return {op, idx, pl};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Presents one request for a single edge, then drops CmdValid.
    task automatic push(input logic [3:0] op, input logic [7:0] idx, input logic [7:0] last,
                        input logic bcast, input logic [22:0] pl);
        CmdOpcode  = op;
        CmdIndex   = idx;
        CmdLast    = last;
        CmdBcast   = bcast;
        CmdPayload = pl;
        CmdValid   = 1'b1;
        step();
        CmdValid   = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        check_val("reset_dataout", DataOut, 35'd0);
        check_val("reset_ready", CmdReady, 1'b1);
        check_val("reset_busy", Busy, 1'b0);
        Reset = 1'b0;
        step();

        // Single command
        push(4'd3, 8'd5, 8'd0, 1'b0, 23'h12345);
        check_val("single_before", DataOut, 35'd0);
        check_val("single_busy", Busy, 1'b1);
        step();
        check_val("single_word", DataOut, word(4'd3, 8'd5, 23'h12345));
        step();
        check_val("single_after", DataOut, 35'd0);
        check_val("single_busy_fall", Busy, 1'b0);

        // Broadcast 10..13 followed by a plain entry
        push(4'd2, 8'd10, 8'd13, 1'b1, 23'd7);
        push(4'd1, 8'd99, 8'd0, 1'b0, 23'd1);
        for (int k = 10; k <= 13; k++) begin
            check_val($sformatf("bcast_idx%0d", k), DataOut, word(4'd2, 8'(k), 23'd7));
            step();
        end
        check_val("bcast_next_entry", DataOut, word(4'd1, 8'd99, 23'd1));
        step();
        check_val("bcast_idle", DataOut, 35'd0);

        // Range ending at 255
        push(4'd4, 8'd254, 8'd255, 1'b1, 23'h3);
        step();
        check_val("top_254", DataOut, word(4'd4, 8'd254, 23'h3));
        step();
        check_val("top_255", DataOut, word(4'd4, 8'd255, 23'h3));
        step();
        check_val("top_nowrap", DataOut, 35'd0);
        check_val("top_busy", Busy, 1'b0);

        // Reversed range issues only the first index
        push(4'd5, 8'd9, 8'd3, 1'b1, 23'h11);
        step();
        check_val("rev_9", DataOut, word(4'd5, 8'd9, 23'h11));
        step();
        check_val("rev_idle", DataOut, 35'd0);

        // Back-pressure
        Stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(4'(k + 1), 8'(40 + k), 8'd0, 1'b0, 23'(k));
        end
        check_val("bp_ready_low", CmdReady, 1'b0);
        check_val("bp_stall_idle", DataOut, 35'd0);
        push(4'd5, 8'd50, 8'd0, 1'b0, 23'h5);
        check_val("bp_ready_still_low", CmdReady, 1'b0);
        check_val("bp_dataout_zero", DataOut, 35'd0);
        Stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("bp_drain%0d", k), DataOut, word(4'(k + 1), 8'(40 + k), 23'(k)));
        end
        step();
        check_val("bp_no_fifth", DataOut, 35'd0);
        check_val("bp_busy", Busy, 1'b0);

        // Stall mid-broadcast 0..3
        push(4'd6, 8'd0, 8'd3, 1'b1, 23'h55);
        step();
        check_val("mstall_0", DataOut, word(4'd6, 8'd0, 23'h55));
        step();
        check_val("mstall_1", DataOut, word(4'd6, 8'd1, 23'h55));
        Stall = 1'b1;
        step();
        check_val("mstall_hold_a", DataOut, 35'd0);
        step();
        check_val("mstall_hold_b", DataOut, 35'd0);
        Stall = 1'b0;
        step();
        check_val("mstall_2", DataOut, word(4'd6, 8'd2, 23'h55));
        step();
        check_val("mstall_3", DataOut, word(4'd6, 8'd3, 23'h55));
        step();
        check_val("mstall_idle", DataOut, 35'd0);

        // Reset mid-broadcast with two entries queued
        push(4'd7, 8'd0, 8'd50, 1'b1, 23'h77);
        push(4'd1, 8'd100, 8'd0, 1'b0, 23'h1);
        push(4'd2, 8'd101, 8'd0, 1'b0, 23'h2);
        check_val("rst_bc_1", DataOut, word(4'd7, 8'd1, 23'h77));
        for (int k = 2; k <= 20; k++) begin
            step();
        end
        check_val("rst_bc_20", DataOut, word(4'd7, 8'd20, 23'h77));
        Reset = 1'b1;
        #1;
        check_val("rst_async_dataout", DataOut, 35'd0);
        check_val("rst_async_busy", Busy, 1'b0);
        step();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("rst_after%0d", k), DataOut, 35'd0);
        end
        check_val("rst_after_busy", Busy, 1'b0);

        // Opcode zero is consumed without issue
        push(4'd0, 8'd3, 8'd0, 1'b0, 23'h9);
        check_val("nop_ready", CmdReady, 1'b1);
        check_val("nop_busy", Busy, 1'b0);
        step();
        check_val("nop_no_word_a", DataOut, 35'd0);
        step();
        check_val("nop_no_word_b", DataOut, 35'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
